alu_pipe: RTL

- Parametrised, pipelined successor to the single-cycle nop/add/sub/mul ALU.
- Adds an extended operation set, a full-width 2*WIDTH result and a result flag.
- Uses fixed-latency in-order pipelining, valid/ready handshakes on both sides, and a credit-protected output FIFO so downstream backpressure never loses a result.
- Sits between the stimulus/driver side and any consumer of ALU results in the datapath.

---
 rtl/alu_pipe_pkg.sv | 23 ++
 rtl/alu_out_fifo.sv | 76 +++++++
 rtl/alu_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: operation encoding and payload helpers.
package alu_types;

  // Operation encoding (3 bits).
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHL = 3'd7
  } operation_t;

  localparam int OP_W = $bits(operation_t);

  // Width of a packed result payload {out, flag, op} for a given operand width.
  function automatic int result_bits(input int width);
    return 2 * width + 1 + OP_W;
  endfunction

endpackage

// File: rtl/alu_out_fifo.sv
// Synchronous FIFO holding finished ALU results. The head entry is presented
// combinationally; an empty FIFO presents all zeros.
module alu_out_fifo
  import alu_types::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push;
  assign count   = count_q;

  // Head of queue, zero while empty so nothing stale is ever visible.
  assign head_data = empty ? '0 : mem[rd_ptr_q];

  // Pointers and occupancy; wrap is explicit so DEPTH need not be a power of two.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the storage array has no reset; occupancy is tracked by count_q and
  // empty entries are masked at the output, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Credits upstream must make a push into a full FIFO impossible unless the
  // head leaves on the same edge.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/alu_pipe.sv
// Pipelined, credit-protected ALU: fixed STAGES-cycle latency, in-order
// results, 2*WIDTH-bit output plus carry/borrow/overflow flag.
module alu_pipe
  import alu_types::*;
#(
  parameter int WIDTH      = 6,
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  operation_t         op_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_flag,
  output operation_t         out_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int UW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = result_bits(WIDTH);

  // Payload carried down the pipe and stored in the FIFO. Declared here
  // because its width follows the WIDTH parameter.
  typedef struct packed {
    logic [2*WIDTH-1:0] out;
    logic               flag;
    operation_t         op;
  } result_t;

  // Full ALU evaluation of one request.
  function automatic result_t alu_eval(input operation_t op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] a2;
    logic [2*WIDTH-1:0] b2;
    logic [2*WIDTH-1:0] r;
    logic [WIDTH:0]     d;
    logic               f;
    result_t            res;
    a2 = {{WIDTH{1'b0}}, a};
    b2 = {{WIDTH{1'b0}}, b};
    r  = '0;
    d  = '0;
    f  = 1'b0;
    case (op)
      OP_ADD: begin
        r = a2 + b2;
        f = r[WIDTH];
      end
      OP_SUB: begin
        d = {1'b0, a} - {1'b0, b};
        r = {{(WIDTH-1){1'b0}}, d};
        f = (a < b);
      end
      OP_MUL: begin
        r = a2 * b2;
        f = |r[2*WIDTH-1:WIDTH];
      end
      OP_AND: r = {{WIDTH{1'b0}}, a & b};
      OP_OR:  r = {{WIDTH{1'b0}}, a | b};
      OP_XOR: r = {{WIDTH{1'b0}}, a ^ b};
      OP_SHL: begin
        r = (int'(b) >= 2 * WIDTH) ? '0 : (a2 << b);
        f = |r[2*WIDTH-1:WIDTH];
      end
      default: begin
        r = '0;
        f = 1'b0;
      end
    endcase
    res.out  = r;
    res.flag = f;
    res.op   = op;
    return res;
  endfunction

  logic            ready_en_q;
  logic [UW-1:0]   used_q;
  logic            accept;
  logic            pop;
  logic [STAGES-1:0] vld_q;
  result_t         pipe_q [STAGES];
  result_t         head;
  logic [RW-1:0]   head_bits;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  assign in_ready  = ready_en_q && (used_q < UW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (used_q != '0);

  // Hold off requests until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // Credit counter: one credit per request from acceptance until its result pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      used_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used_q <= used_q + UW'(1);
        2'b01:   used_q <= used_q - UW'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  // Valid bits of the stall-free pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Pipeline payload; the result is computed on entry and carried unchanged.
  always_ff @(posedge clk) begin
    pipe_q[0] <= alu_eval(op_in, a_in, b_in);
    for (int i = 1; i < STAGES; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  alu_out_fifo #(
    .DW    (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (vld_q[STAGES-1]),
    .push_data (pipe_q[STAGES-1]),
    .pop       (pop),
    .head_data (head_bits),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head     = result_t'(head_bits);
  assign out      = head.out;
  assign out_flag = head.flag;
  assign out_op   = head.op;

endmodule
